// File: rtl/game_round_sequencer_if.sv
// =============================================================================
// Module      : game_round_sequencer_if
// Description : Input/status bundle between the round sequencer and the
//               start button, wall datapath and renderer/HUD.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface game_round_sequencer_if;
    logic       start_in;
    logic       new_frame_in;
    logic       wall_done_in;
    logic       collision_in;
    logic [2:0] game_state_out;
    logic [3:0] wall_idx_out;
    logic [3:0] frames_per_tick_out;
    logic       wall_rst_out;
    logic       wall_run_out;
    logic [2:0] lives_out;
    logic [7:0] score_out;
    logic [7:0] round_out;
    logic [7:0] countdown_out;
    logic       result_pass_out;

    modport master (
        input  start_in, new_frame_in, wall_done_in, collision_in,
        output game_state_out, wall_idx_out, frames_per_tick_out, wall_rst_out,
               wall_run_out, lives_out, score_out, round_out, countdown_out,
               result_pass_out
    );

    modport slave (
        output start_in, new_frame_in, wall_done_in, collision_in,
        input  game_state_out, wall_idx_out, frames_per_tick_out, wall_rst_out,
               wall_run_out, lives_out, score_out, round_out, countdown_out,
               result_pass_out
    );
endinterface

`default_nettype wire

// File: rtl/game_round_sequencer.sv
// =============================================================================
// Module      : game_round_sequencer
// Description : Round-level controller: countdown, play, result and game-over
//               phases; drives wall config, lives, score and round status.
//               Optional macro PRACTICE_MODE_EN: lives never decrement.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module game_round_sequencer #(
    parameter int NUM_WALLS                = 10,
    parameter int MAX_FRAMES_PER_WALL_TICK = 15,
    parameter int MIN_FRAMES_PER_WALL_TICK = 3,
    parameter int SPEEDUP_EVERY            = 2,
    parameter int COUNTDOWN_FRAMES         = 180,
    parameter int RESULT_FRAMES            = 90,
    parameter int START_LIVES              = 3
) (
    input  wire logic              clk_in,
    input  wire logic              rst_n_in,
    game_round_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAYING   = 3'd2,
        ST_RESULT    = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam logic [7:0] c_cd_frames   = 8'(COUNTDOWN_FRAMES);
    localparam logic [7:0] c_res_frames  = 8'(RESULT_FRAMES);
    localparam logic [3:0] c_fpt_max     = 4'(MAX_FRAMES_PER_WALL_TICK);
    localparam logic [3:0] c_fpt_min     = 4'(MIN_FRAMES_PER_WALL_TICK);
    localparam logic [2:0] c_lives_start = 3'(START_LIVES);
    localparam logic [3:0] c_last_wall   = 4'(NUM_WALLS - 1);
    localparam logic [7:0] c_speedup     = 8'(SPEEDUP_EVERY);

    state_t     r_state;
    logic       r_start_q;
    logic [7:0] r_frame_cnt;
    logic [7:0] r_countdown;
    logic [3:0] r_wall_idx;
    logic [3:0] r_fpt;
    logic       r_wall_rst;
    logic       r_wall_run;
    logic [2:0] r_lives;
    logic [7:0] r_score;
    logic [7:0] r_round;
    logic       r_result_pass;
    logic       r_hit;
    logic [7:0] r_passes;

    logic w_start_edge;
    logic w_round_hit;
    logic w_lives_out;

    assign w_start_edge = bus.start_in & ~r_start_q;
    assign w_round_hit  = r_hit | bus.collision_in;

`ifdef PRACTICE_MODE_EN
    assign w_lives_out = 1'b0;
`else
    assign w_lives_out = (r_lives == 3'd0);
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= ST_IDLE;
            r_start_q     <= 1'b0;
            r_frame_cnt   <= 8'd0;
            r_countdown   <= 8'd0;
            r_wall_idx    <= 4'd0;
            r_fpt         <= c_fpt_max;
            r_wall_rst    <= 1'b1;
            r_wall_run    <= 1'b0;
            r_lives       <= 3'd0;
            r_score       <= 8'd0;
            r_round       <= 8'd0;
            r_result_pass <= 1'b0;
            r_hit         <= 1'b0;
            r_passes      <= 8'd0;
        end else begin
            r_start_q <= bus.start_in;
            case (r_state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (w_start_edge) begin
                        r_state     <= ST_COUNTDOWN;
                        r_lives     <= c_lives_start;
                        r_score     <= 8'd0;
                        r_round     <= 8'd0;
                        r_wall_idx  <= 4'd0;
                        r_fpt       <= c_fpt_max;
                        r_passes    <= 8'd0;
                        r_frame_cnt <= 8'd0;
                        r_countdown <= c_cd_frames;
                        r_hit       <= 1'b0;
                    end
                end
                ST_COUNTDOWN: begin
                    if (bus.new_frame_in) begin
                        if (r_frame_cnt == c_cd_frames - 8'd1) begin
                            r_state     <= ST_PLAYING;
                            r_frame_cnt <= 8'd0;
                            r_countdown <= 8'd0;
                            r_wall_rst  <= 1'b0;
                            r_wall_run  <= 1'b1;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                            r_countdown <= c_cd_frames - (r_frame_cnt + 8'd1);
                        end
                    end
                end
                ST_PLAYING: begin
                    if (bus.wall_done_in) begin
                        r_state       <= ST_RESULT;
                        r_wall_rst    <= 1'b1;
                        r_wall_run    <= 1'b0;
                        r_frame_cnt   <= 8'd0;
                        r_countdown   <= c_res_frames;
                        r_result_pass <= ~w_round_hit;
                        if (r_round != 8'hFF) r_round <= r_round + 8'd1;
                        r_wall_idx <= (r_wall_idx == c_last_wall) ? 4'd0 : r_wall_idx + 4'd1;
                        if (w_round_hit) begin
`ifdef PRACTICE_MODE_EN
                            r_lives <= r_lives;
`else
                            if (r_lives != 3'd0) r_lives <= r_lives - 3'd1;
`endif
                        end else begin
                            if (r_score != 8'hFF) r_score <= r_score + 8'd1;
                            // Speed steps only on passed rounds, never below the floor
                            if (r_passes + 8'd1 >= c_speedup) begin
                                r_passes <= 8'd0;
                                if (r_fpt > c_fpt_min) r_fpt <= r_fpt - 4'd1;
                            end else begin
                                r_passes <= r_passes + 8'd1;
                            end
                        end
                    end else if (bus.collision_in) begin
                        r_hit <= 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (bus.new_frame_in) begin
                        if (r_frame_cnt == c_res_frames - 8'd1) begin
                            r_frame_cnt <= 8'd0;
                            if (w_lives_out) begin
                                r_state     <= ST_GAME_OVER;
                                r_countdown <= 8'd0;
                            end else begin
                                r_state     <= ST_COUNTDOWN;
                                r_countdown <= c_cd_frames;
                                r_hit       <= 1'b0;
                            end
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                            r_countdown <= c_res_frames - (r_frame_cnt + 8'd1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.game_state_out      = r_state;
    assign bus.wall_idx_out        = r_wall_idx;
    assign bus.frames_per_tick_out = r_fpt;
    assign bus.wall_rst_out        = r_wall_rst;
    assign bus.wall_run_out        = r_wall_run;
    assign bus.lives_out           = r_lives;
    assign bus.score_out           = r_score;
    assign bus.round_out           = r_round;
    assign bus.countdown_out       = r_countdown;
    assign bus.result_pass_out     = r_result_pass;

endmodule

`default_nettype wire

// File: tb/tb_game_round_sequencer.sv
// =============================================================================
// Module      : tb_game_round_sequencer
// Description : Directed and randomized rounds for game_round_sequencer against
//               a score/lives/speed reference model.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_game_round_sequencer;

    localparam int NUM_WALLS = 10;
    localparam int MAXF      = 15;
    localparam int MINF      = 3;
    localparam int SPEEDUP   = 2;
    localparam int CD        = 3;
    localparam int RES       = 2;
    localparam int LIVES0    = 2;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    game_round_sequencer_if bus();

    game_round_sequencer #(
        .NUM_WALLS               (NUM_WALLS),
        .MAX_FRAMES_PER_WALL_TICK(MAXF),
        .MIN_FRAMES_PER_WALL_TICK(MINF),
        .SPEEDUP_EVERY           (SPEEDUP),
        .COUNTDOWN_FRAMES        (CD),
        .RESULT_FRAMES           (RES),
        .START_LIVES             (LIVES0)
    ) dut (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Game-level model: totals since the last start, not per-cycle state
    int m_lives, m_score, m_round, m_idx, m_passes_total;
    bit m_over;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int m_fpt();
        int v;
        v = MAXF - m_passes_total / SPEEDUP;
        return (v < MINF) ? MINF : v;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic frame();
        bus.new_frame_in = 1'b1;
        tick();
        bus.new_frame_in = 1'b0;
        tick();
    endtask

    task automatic start_edge();
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
        tick();
    endtask

    task automatic new_game();
        m_lives = LIVES0; m_score = 0; m_round = 0; m_idx = 0; m_passes_total = 0;
        m_over = 1'b0;
        check("reload_state", 32'(bus.game_state_out), 1);
        check("reload_lives", 32'(bus.lives_out), LIVES0);
        check("reload_score", 32'(bus.score_out), 0);
        check("reload_round", 32'(bus.round_out), 0);
        check("reload_idx", 32'(bus.wall_idx_out), 0);
        check("reload_fpt", 32'(bus.frames_per_tick_out), MAXF);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"}, 32'(bus.game_state_out), 0);
        check({tag, "_idx"}, 32'(bus.wall_idx_out), 0);
        check({tag, "_fpt"}, 32'(bus.frames_per_tick_out), MAXF);
        check({tag, "_wall_rst"}, 32'(bus.wall_rst_out), 1);
        check({tag, "_wall_run"}, 32'(bus.wall_run_out), 0);
        check({tag, "_lives"}, 32'(bus.lives_out), 0);
        check({tag, "_score"}, 32'(bus.score_out), 0);
        check({tag, "_round"}, 32'(bus.round_out), 0);
        check({tag, "_countdown"}, 32'(bus.countdown_out), 0);
        check({tag, "_pass"}, 32'(bus.result_pass_out), 0);
    endtask

    task automatic run_countdown();
        check("cd_state", 32'(bus.game_state_out), 1);
        check("cd_len", 32'(bus.countdown_out), CD);
        check("cd_wall_run", 32'(bus.wall_run_out), 0);
        if ($urandom_range(0, 1) == 1) begin
            bus.collision_in = 1'b1;
            bus.wall_done_in = 1'b1;
            tick();
            bus.collision_in = 1'b0;
            bus.wall_done_in = 1'b0;
            tick();
        end
        for (int i = 1; i <= CD; i++) begin
            frame();
            if (i < CD) check("cd_remaining", 32'(bus.countdown_out), CD - i);
        end
        check("play_state", 32'(bus.game_state_out), 2);
        check("play_wall_run", 32'(bus.wall_run_out), 1);
        check("play_wall_rst", 32'(bus.wall_rst_out), 0);
        check("play_idx", 32'(bus.wall_idx_out), m_idx);
        check("play_fpt", 32'(bus.frames_per_tick_out), m_fpt());
    endtask

    // mode 0: clean pass, 1: collision mid-round, 2: collision with wall_done
    task automatic play_round(input int mode, input bit hold_start);
        bit hit;
        bus.start_in = hold_start;
        repeat ($urandom_range(0, 3)) tick();
        if ($urandom_range(0, 1) == 1) frame();
        if (mode == 1) begin
            bus.collision_in = 1'b1;
            tick();
            bus.collision_in = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        bus.wall_done_in = 1'b1;
        bus.collision_in = (mode == 2);
        tick();
        bus.wall_done_in = 1'b0;
        bus.collision_in = 1'b0;
        bus.start_in     = 1'b0;

        hit     = (mode != 0);
        m_round = (m_round < 255) ? m_round + 1 : 255;
        m_idx   = (m_idx + 1) % NUM_WALLS;
        if (hit) begin
`ifndef PRACTICE_MODE_EN
            if (m_lives > 0) m_lives--;
`endif
        end else begin
            m_score = (m_score < 255) ? m_score + 1 : 255;
            m_passes_total++;
        end

        check("res_state", 32'(bus.game_state_out), 3);
        check("res_pass", 32'(bus.result_pass_out), 32'(!hit));
        check("res_lives", 32'(bus.lives_out), m_lives);
        check("res_score", 32'(bus.score_out), m_score);
        check("res_round", 32'(bus.round_out), m_round);
        check("res_idx", 32'(bus.wall_idx_out), m_idx);
        check("res_fpt", 32'(bus.frames_per_tick_out), m_fpt());
        check("res_wall_run", 32'(bus.wall_run_out), 0);
        check("res_wall_rst", 32'(bus.wall_rst_out), 1);
        check("res_len", 32'(bus.countdown_out), RES);

        bus.wall_done_in = 1'b1;
        tick();
        bus.wall_done_in = 1'b0;
        frame();
        check("res_remaining", 32'(bus.countdown_out), RES - 1);
        check("res_round_held", 32'(bus.round_out), m_round);
        frame();

`ifdef PRACTICE_MODE_EN
        m_over = 1'b0;
`else
        m_over = (m_lives == 0);
`endif
        check("res_exit_state", 32'(bus.game_state_out), m_over ? 4 : 1);
    endtask

    task automatic round_and_continue(input int mode, input bit hold_start);
        play_round(mode, hold_start);
        if (m_over) begin
            check("go_wall_run", 32'(bus.wall_run_out), 0);
            check("go_countdown", 32'(bus.countdown_out), 0);
            start_edge();
            new_game();
        end
        run_countdown();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        bus.start_in     = 1'b0;
        bus.new_frame_in = 1'b0;
        bus.wall_done_in = 1'b0;
        bus.collision_in = 1'b0;
        rst_n_in         = 1'b0;
        tick();
        tick();
        check_reset("reset");
        rst_n_in = 1'b1;
        frame();
        check("idle_state", 32'(bus.game_state_out), 0);

        start_edge();
        new_game();
        run_countdown();

        play_round(0, 1'b0); run_countdown();
        play_round(0, 1'b0); run_countdown();
        check("speedup_after_two", 32'(bus.frames_per_tick_out), 14);
        play_round(1, 1'b0); run_countdown();
        check("mid_hit_lives", 32'(bus.lives_out), 1);
        play_round(2, 1'b0);

`ifdef PRACTICE_MODE_EN
        run_countdown();
        for (int i = 0; i < 3; i++) begin
            play_round(1 + (i % 2), 1'b0);
            run_countdown();
        end
        check("practice_lives", 32'(bus.lives_out), LIVES0);
`else
        check("gameover_state", 32'(bus.game_state_out), 4);
        check("gameover_lives", 32'(bus.lives_out), 0);
        bus.wall_done_in = 1'b1;
        bus.collision_in = 1'b1;
        tick();
        bus.wall_done_in = 1'b0;
        bus.collision_in = 1'b0;
        frame();
        check("gameover_round_held", 32'(bus.round_out), 4);
        check("gameover_score_held", 32'(bus.score_out), 2);
        check("gameover_stays", 32'(bus.game_state_out), 4);
        start_edge();
        new_game();
        run_countdown();
`endif

        for (int i = 0; i < 30; i++) begin
            play_round(0, 1'($urandom_range(0, 1)));
            run_countdown();
        end
        check("floor_fpt", 32'(bus.frames_per_tick_out), MINF);

        for (int i = 0; i < 14; i++) begin
            r = int'($urandom_range(0, 3));
            round_and_continue((r < 2) ? 0 : r - 1, 1'($urandom_range(0, 1)));
        end

        check("pre_reset_playing", 32'(bus.game_state_out), 2);
        #3;
        rst_n_in = 1'b0;
        #1;
        check_reset("async_reset");
        tick();
        rst_n_in = 1'b1;
        tick();
        check("post_reset_idle", 32'(bus.game_state_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/game_round_sequencer.md
Name: game_round_sequencer

Overview:
Round-level controller that sequences the wall/collision datapath (game_logic_controller) through countdown, play, result and game-over phases. Selects the wall bitmask index, sets wall speed (frames per wall tick), and holds or releases the wall. Tracks lives, score and round number. Sits between user input (start button) and the per-pixel game logic; consumes frame and wall-done pulses, drives configuration and status registers read by the renderer/HUD.

Parameters:
NUM_WALLS, 10, number of stored wall bitmasks; wall_idx wraps at NUM_WALLS-1
MAX_FRAMES_PER_WALL_TICK, 15, initial (slowest) frames per wall tick
MIN_FRAMES_PER_WALL_TICK, 3, speed floor
SPEEDUP_EVERY, 2, passed rounds between speed steps
COUNTDOWN_FRAMES, 180, frames spent in COUNTDOWN
RESULT_FRAMES, 90, frames spent in RESULT
START_LIVES, 3, lives loaded at game start (1..7)

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous, active-low reset
start_in  input  1  start button level (synchronised/debounced upstream)
new_frame_in  input  1  one-cycle pulse per video frame
wall_done_in  input  1  one-cycle pulse when wall reaches max depth
collision_in  input  1  high in any cycle with a pixel collision inside the goal window
game_state_out  output  3  0 IDLE, 1 COUNTDOWN, 2 PLAYING, 3 RESULT, 4 GAME_OVER
wall_idx_out  output  4  bitmask index for datapath
frames_per_tick_out  output  4  wall tick period for datapath
wall_rst_out  output  1  holds wall depth/tick counters in reset
wall_run_out  output  1  enables wall motion
lives_out  output  3  remaining lives
score_out  output  8  rounds passed, saturates at 255
round_out  output  8  rounds completed, saturates at 255
countdown_out  output  8  frames remaining in current COUNTDOWN/RESULT phase
result_pass_out  output  1  outcome of last round (1 = pass)

Behaviour:
- All outputs registered. Async reset (rst_n_in low): state IDLE, wall_idx 0, frames_per_tick MAX_FRAMES_PER_WALL_TICK, wall_rst 1, wall_run 0, lives 0, score 0, round 0, countdown 0, result_pass 0, hit flag 0, frame counter 0, start_q 0. Reset may assert in any state; outputs clear immediately.
- start_q registers start_in; start edge = start_in & ~start_q. Edges ignored except in IDLE and GAME_OVER.
- Frame counter: counts new_frame_in pulses; cleared on every state transition; countdown_out = phase length - count.
- IDLE: wall_rst 1, wall_run 0. Start edge -> COUNTDOWN next cycle; load lives=START_LIVES, score=0, round=0, wall_idx=0, frames_per_tick=MAX, passes_since_speedup=0.
- COUNTDOWN: wall_rst 1, wall_run 0. When count reaches COUNTDOWN_FRAMES -> PLAYING; hit flag cleared on entry.
- PLAYING: wall_rst 0, wall_run 1. collision_in sets sticky hit flag. wall_done_in -> RESULT. collision_in in same cycle as wall_done_in counts as hit.
- RESULT entry (single update, cycle after wall_done_in): wall_rst 1, wall_run 0; result_pass = ~hit; round +1 saturating; wall_idx +1, NUM_WALLS-1 wraps to 0. Hit: lives -1 (never below 0). Pass: score +1 saturating; passes_since_speedup +1; on reaching SPEEDUP_EVERY it resets to 0 and frames_per_tick -1, floored at MIN.
- RESULT exit after RESULT_FRAMES frames: lives==0 -> GAME_OVER, else COUNTDOWN.
- GAME_OVER: wall_rst 1, wall_run 0; score/round/lives held. Start edge -> COUNTDOWN with the same reload as IDLE.
- wall_done_in and collision_in ignored outside PLAYING. new_frame_in coincident with a transition does not count toward the next phase.

Optional Feature:
PRACTICE_MODE_EN: when defined, lives never decrement, GAME_OVER is unreachable, and result_pass/score still update normally. When undefined, behaviour as above.

Test Plan:
- Sim params COUNTDOWN_FRAMES=3, RESULT_FRAMES=2, START_LIVES=2. Reset, start edge, 3 frames -> state 1 then 2; wall_run 1, wall_rst 0, wall_idx 0, frames_per_tick 15.
- PLAYING, no collision, wall_done -> RESULT, result_pass 1, score 1, round 1, wall_idx 1; second pass -> frames_per_tick 14.
- Collision pulse mid-round then wall_done -> lives 1, score unchanged; collision together with wall_done also counts as hit.
- Two hit rounds -> lives 0, after 2 frames state 4; start edge -> COUNTDOWN, lives 2, score 0, round 0.
- 10 passes -> wall_idx wraps 9->0; 30 passes -> frames_per_tick floors at 3; start_in held high during play -> no effect.
- rst_n_in low mid-PLAYING -> all outputs return to reset values asynchronously; PRACTICE_MODE_EN build: 5 hits -> lives stays 2, never state 4.
